// File: rtl/tw_gen.sv
// Twiddle table writer: fills a RAM with root^k*R mod Q (Montgomery domain)
// at bit-reversed addresses, one bit-serial Montgomery multiply per entry.
module tw_gen #(
  parameter int              LOGN = 3,
  parameter int              LOGQ = 64,
  parameter logic [LOGQ-1:0] Q    = 64'd9223372036855300097
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LOGQ-1:0] root_in,
  input  logic [LOGQ-1:0] one_in,
  output logic            busy,
  output logic            done,
  output logic            we,
  output logic [LOGN-1:0] waddr,
  output logic [LOGQ-1:0] wdata
);

  localparam int              IW        = (LOGQ > 1) ? $clog2(LOGQ) : 1;
  localparam logic [LOGN-1:0] K_LAST    = LOGN'((1 << LOGN) - 1);
  localparam logic [IW-1:0]   I_LAST    = IW'(LOGQ - 1);
  localparam logic [LOGQ:0]   Q_HALF_UP = ({1'b0, Q} + (LOGQ+1)'(1)) >> 1;

  typedef enum logic [2:0] {IDLE, WR, MUL, CORR, DONE} state_t;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
    logic [LOGN-1:0] r;
    for (int b = 0; b < LOGN; b++) r[b] = x[LOGN-1-b];
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [LOGQ-1:0] root_q, root_d;
  logic [LOGQ-1:0] cur_q, cur_d;
  logic [LOGQ:0]   acc_q, acc_d;
  logic [LOGN-1:0] k_q, k_d;
  logic [IW-1:0]   i_q, i_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            we_q, we_d;
  logic [LOGN-1:0] waddr_q, waddr_d;
  logic [LOGQ-1:0] wdata_q, wdata_d;

  logic [LOGQ+1:0] t_sum;
  logic [LOGQ:0]   acc_step;
  logic [LOGQ-1:0] acc_sub;
  logic [LOGQ-1:0] cur_red;
  logic [LOGN-1:0] k_inc;

  // Both t_sum and Q are odd in the add-Q case, so (t+Q)>>1 == (t>>1) + (Q+1)/2.
  assign t_sum    = {1'b0, acc_q} + (cur_q[i_q] ? {2'b00, root_q} : '0);
  assign acc_step = t_sum[LOGQ+1:1] + (t_sum[0] ? Q_HALF_UP : '0);
  assign acc_sub  = acc_q[LOGQ-1:0] - Q;
  assign cur_red  = (acc_q >= {1'b0, Q}) ? acc_sub : acc_q[LOGQ-1:0];
  assign k_inc    = k_q + LOGN'(1);

  always_comb begin
    state_d = state_q;
    root_d  = root_q;
    cur_d   = cur_q;
    acc_d   = acc_q;
    k_d     = k_q;
    i_d     = i_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          root_d  = root_in;
          cur_d   = one_in;
          k_d     = '0;
          state_d = WR;
          busy_d  = 1'b1;
          we_d    = 1'b1;
          waddr_d = '0;
          wdata_d = one_in;
        end
      end
      WR: begin
        if (k_q == K_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          acc_d   = '0;
          i_d     = '0;
          state_d = MUL;
          busy_d  = 1'b1;
        end
      end
      MUL: begin
        acc_d  = acc_step;
        i_d    = i_q + IW'(1);
        busy_d = 1'b1;
        if (i_q == I_LAST) state_d = CORR;
      end
      CORR: begin
        cur_d   = cur_red;
        k_d     = k_inc;
        state_d = WR;
        busy_d  = 1'b1;
        we_d    = 1'b1;
        waddr_d = bitrev(k_inc);
        wdata_d = cur_red;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      root_q  <= '0;
      cur_q   <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      i_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      root_q  <= root_d;
      cur_q   <= cur_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      i_q     <= i_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_tw_gen.sv
// Directed bench for tw_gen: one LOGN=2 and one LOGN=3 instance, selected by
// 'sel', with hand-computed write sequences and a wide-arithmetic model.
module tb_tw_gen;

  localparam logic [63:0] Q   = 64'd9223372036855300097;
  localparam logic [63:0] ONE = 64'd9223372036854251519;
  localparam logic [63:0] QM1 = 64'd1048578;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [63:0] root_in = '0;
  logic [63:0] one_in = '0;

  logic        start2, start3;
  logic        busy2, done2, we2, busy3, done3, we3;
  logic [1:0]  waddr2;
  logic [2:0]  waddr3;
  logic [63:0] wdata2, wdata3;
  logic        m_busy, m_done, m_we;
  logic [2:0]  m_waddr;
  logic [63:0] m_wdata;

  assign start2  = start & ~sel;
  assign start3  = start & sel;
  assign m_busy  = sel ? busy3 : busy2;
  assign m_done  = sel ? done3 : done2;
  assign m_we    = sel ? we3 : we2;
  assign m_waddr = sel ? waddr3 : {1'b0, waddr2};
  assign m_wdata = sel ? wdata3 : wdata2;

  tw_gen #(.LOGN(2), .LOGQ(64), .Q(Q)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .root_in(root_in), .one_in(one_in),
    .busy(busy2), .done(done2), .we(we2), .waddr(waddr2), .wdata(wdata2)
  );

  tw_gen #(.LOGN(3), .LOGQ(64), .Q(Q)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .root_in(root_in), .one_in(one_in),
    .busy(busy3), .done(done3), .we(we3), .waddr(waddr3), .wdata(wdata3)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          nwr, done_cyc, busy_cnt;
  int          wr_cyc [16];
  logic [2:0]  wr_addr [16];
  logic [63:0] wr_data [16];
  logic [63:0] rinv;
  logic [2:0]  a2 [4] = '{3'd0, 3'd2, 3'd1, 3'd3};
  logic [2:0]  a3 [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

  function automatic logic [63:0] calc_rinv();
    logic [64:0] x;
    x = 65'd1;
    repeat (64) x = x[0] ? ((x + {1'b0, Q}) >> 1) : (x >> 1);
    return x[63:0];
  endfunction

  // a*b*2^-64 mod Q via a full 128-bit product and a precomputed inverse radix
  function automatic logic [63:0] mont(input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    p = ({64'd0, a} * {64'd0, b}) % {64'd0, Q};
    p = (p * {64'd0, rinv}) % {64'd0, Q};
    return p[63:0];
  endfunction

  function automatic logic [63:0] rand_reduced();
    logic [63:0] v;
    v = {$urandom, $urandom};
    if (v >= Q) v = v - Q;
    return v;
  endfunction

  // Starts a fill (cycle 0 = the cycle start is sampled) and records writes
  // until the done pulse; start is re-pulsed in cycles s1 and s2.
  task automatic run_fill(input logic [63:0] r, input logic [63:0] o, input int s1, input int s2);
    int budget;
    budget = (sel ? 464 : 200) + 20;
    nwr = 0; done_cyc = -1; busy_cnt = 0;
    @(negedge clk);
    root_in = r; one_in = o; start = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (m_we) begin
        if (nwr < 16) begin
          wr_cyc[nwr] = c; wr_addr[nwr] = m_waddr; wr_data[nwr] = m_wdata;
        end
        nwr++;
      end
      if (m_busy) busy_cnt++;
      if (m_done && done_cyc < 0) done_cyc = c;
      start = (c == s1) || (c == s2);
      if (m_done) break;
    end
    if (done_cyc < 0) begin
      checks++; errors++;
      $display("[TB] FAIL fill_timeout: no done within %0d cycles, required one done pulse", budget);
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({m_busy, m_done, m_we, m_waddr, m_wdata} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs(sel=%0d): busy=%0b done=%0b we=%0b waddr=%0d wdata=%0d, required all 0",
                 s, m_busy, m_done, m_we, m_waddr, m_wdata);
      end
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_identity();
    sel = 1'b0;
    run_fill(ONE, ONE, -1, -1);
    checks++; if (nwr !== 4) begin errors++; $display("[TB] FAIL ident_count: got %0d writes, required 4", nwr); end
    checks++; if (done_cyc !== 200) begin errors++; $display("[TB] FAIL ident_done_cycle: got %0d, required 200", done_cyc); end
    checks++; if (busy_cnt !== 199) begin errors++; $display("[TB] FAIL ident_busy_cycles: got %0d, required 199", busy_cnt); end
    for (int k = 0; k < 4 && k < nwr; k++) begin
      checks++; if (wr_addr[k] !== a2[k]) begin errors++; $display("[TB] FAIL ident_addr[%0d]: got %0d, required %0d", k, wr_addr[k], a2[k]); end
      checks++; if (wr_data[k] !== ONE) begin errors++; $display("[TB] FAIL ident_data[%0d]: got %0d, required %0d", k, wr_data[k], ONE); end
      checks++; if (wr_cyc[k] !== 1 + 66*k) begin errors++; $display("[TB] FAIL ident_cycle[%0d]: got %0d, required %0d", k, wr_cyc[k], 1 + 66*k); end
    end
  endtask

  task automatic test_minus_one();
    logic [63:0] exp;
    sel = 1'b0;
    run_fill(QM1, ONE, -1, -1);
    checks++; if (nwr !== 4) begin errors++; $display("[TB] FAIL m1_count: got %0d writes, required 4", nwr); end
    for (int k = 0; k < 4 && k < nwr; k++) begin
      exp = (k % 2 == 0) ? ONE : QM1;
      checks++; if (wr_addr[k] !== a2[k]) begin errors++; $display("[TB] FAIL m1_addr[%0d]: got %0d, required %0d", k, wr_addr[k], a2[k]); end
      checks++; if (wr_data[k] !== exp) begin errors++; $display("[TB] FAIL m1_data[%0d]: got %0d, required %0d", k, wr_data[k], exp); end
    end
  endtask

  task automatic test_zero_root();
    logic [63:0] exp;
    sel = 1'b1;
    run_fill(64'd0, 64'd5, -1, -1);
    checks++; if (nwr !== 8) begin errors++; $display("[TB] FAIL zero_count: got %0d writes, required 8", nwr); end
    checks++; if (done_cyc !== 464) begin errors++; $display("[TB] FAIL zero_done_cycle: got %0d, required 464", done_cyc); end
    for (int k = 0; k < 8 && k < nwr; k++) begin
      exp = (k == 0) ? 64'd5 : 64'd0;
      checks++; if (wr_addr[k] !== a3[k]) begin errors++; $display("[TB] FAIL zero_addr[%0d]: got %0d, required %0d", k, wr_addr[k], a3[k]); end
      checks++; if (wr_data[k] !== exp) begin errors++; $display("[TB] FAIL zero_data[%0d]: got %0d, required %0d", k, wr_data[k], exp); end
    end
  endtask

  task automatic test_random_roots();
    logic [63:0] r, o, exp;
    sel = 1'b0;
    for (int n = 0; n < 50; n++) begin
      r = rand_reduced();
      o = rand_reduced();
      run_fill(r, o, -1, -1);
      checks++; if (nwr !== 4) begin errors++; $display("[TB] FAIL rand_count[%0d]: got %0d writes, required 4", n, nwr); end
      exp = o;
      for (int k = 0; k < 4 && k < nwr; k++) begin
        checks++; if (wr_data[k] !== exp) begin errors++; $display("[TB] FAIL rand_data[%0d][%0d]: got %0d, required %0d", n, k, wr_data[k], exp); end
        checks++; if (!(wr_data[k] < Q)) begin errors++; $display("[TB] FAIL rand_reduced[%0d][%0d]: got %0d, required < %0d", n, k, wr_data[k], Q); end
        exp = mont(exp, r);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    int          stray;
    logic [63:0] exp;
    sel = 1'b1;
    @(negedge clk);
    root_in = ONE; one_in = ONE; start = 1'b1;
    for (int c = 1; c <= 220; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++; if (m_busy !== 1'b1) begin errors++; $display("[TB] FAIL midfill_busy_before: got %0b, required 1", m_busy); end
    rst = 1'b1;
    #1;
    checks++;
    if ({m_busy, m_done, m_we, m_waddr, m_wdata} !== '0) begin
      errors++;
      $display("[TB] FAIL midfill_reset_outputs: busy=%0b done=%0b we=%0b waddr=%0d wdata=%0d, required all 0",
               m_busy, m_done, m_we, m_waddr, m_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (m_we || m_busy || m_done) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL midfill_quiet: got %0d active cycles, required 0", stray); end
    run_fill(QM1, ONE, -1, -1);
    checks++; if (nwr !== 8) begin errors++; $display("[TB] FAIL refill_count: got %0d writes, required 8", nwr); end
    checks++; if (done_cyc !== 464) begin errors++; $display("[TB] FAIL refill_done_cycle: got %0d, required 464", done_cyc); end
    for (int k = 0; k < 8 && k < nwr; k++) begin
      exp = (k % 2 == 0) ? ONE : QM1;
      checks++; if (wr_addr[k] !== a3[k]) begin errors++; $display("[TB] FAIL refill_addr[%0d]: got %0d, required %0d", k, wr_addr[k], a3[k]); end
      checks++; if (wr_data[k] !== exp) begin errors++; $display("[TB] FAIL refill_data[%0d]: got %0d, required %0d", k, wr_data[k], exp); end
    end
  endtask

  task automatic test_start_handling();
    int stray;
    sel = 1'b0;
    run_fill(ONE, ONE, 50, 200);
    checks++; if (nwr !== 4) begin errors++; $display("[TB] FAIL sh_count: got %0d writes, required 4", nwr); end
    checks++; if (done_cyc !== 200) begin errors++; $display("[TB] FAIL sh_done_cycle: got %0d, required 200", done_cyc); end
    for (int k = 0; k < 4 && k < nwr; k++) begin
      checks++; if (wr_cyc[k] !== 1 + 66*k) begin errors++; $display("[TB] FAIL sh_cycle[%0d]: got %0d, required %0d", k, wr_cyc[k], 1 + 66*k); end
    end
    @(negedge clk);
    start = 1'b0;
    stray = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m_we || m_busy) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("[TB] FAIL sh_done_start_ignored: got %0d active cycles, required 0", stray); end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    run_fill(ONE, ONE, -1, -1);
    run_fill(QM1, ONE, -1, -1);
    checks++; if (nwr !== 4) begin errors++; $display("[TB] FAIL b2b_count: got %0d writes, required 4", nwr); end
    checks++; if (done_cyc !== 200) begin errors++; $display("[TB] FAIL b2b_done_cycle: got %0d, required 200", done_cyc); end
    if (nwr >= 2) begin
      checks++; if (wr_cyc[0] !== 1) begin errors++; $display("[TB] FAIL b2b_first_cycle: got %0d, required 1", wr_cyc[0]); end
      checks++; if (wr_data[1] !== QM1) begin errors++; $display("[TB] FAIL b2b_data[1]: got %0d, required %0d", wr_data[1], QM1); end
    end
  endtask

  initial begin
    rinv = calc_rinv();
    test_reset();
    test_identity();
    test_minus_one();
    test_zero_root();
    test_random_roots();
    test_reset_mid_fill();
    test_start_handling();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
